// File: rtl/trivium_pkg.sv
// Shared constants and state encoding for the Trivium keystream sequencer.
package trivium_pkg;
   localparam int KEY_W        = 80;
   localparam int IV_W         = 80;
   localparam int STATE_W      = 288;
   localparam int WARMUP_STEPS = 4 * STATE_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WARM  = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4
   } state_e;
endpackage

// File: rtl/ks_packer.sv
// Packs keystream bits MSB-first into words and presents them on a valid/ready output.
module ks_packer #(
   parameter int WORD_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_clr,
   input  logic              i_step,
   input  logic              i_z,
   input  logic              i_last,
   input  logic              i_ks_ready,
   output logic              o_stall,
   output logic              o_move,
   output logic [WORD_W-1:0] o_ks_data,
   output logic              o_ks_valid
);
   localparam int CW = $clog2(WORD_W);

   logic [WORD_W-1:0] r_sr;
   logic [CW-1:0]     r_cnt;
   logic              r_full;
   logic [CW-1:0]     w_shamt;
   logic [WORD_W-1:0] w_aligned;

   // r_cnt is 0 for a complete word, so the modular negate gives a zero shift there
   // and left-aligns a short final word otherwise.
   assign w_shamt   = -r_cnt;
   assign w_aligned = r_sr << w_shamt;
   assign o_move    = r_full && (!o_ks_valid || i_ks_ready);
   assign o_stall   = r_full && !o_move;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sr       <= '0;
         r_cnt      <= '0;
         r_full     <= 1'b0;
         o_ks_data  <= '0;
         o_ks_valid <= 1'b0;
      end else if (i_clr) begin
         r_cnt      <= '0;
         r_full     <= 1'b0;
         o_ks_valid <= 1'b0;
      end else begin
         if (i_step)
            r_sr <= {r_sr[WORD_W-2:0], i_z};
         if (o_move)
            r_cnt <= {{(CW-1){1'b0}}, i_step};
         else if (i_step)
            r_cnt <= r_cnt + CW'(1);
         if (o_move)
            r_full <= 1'b0;
         if (i_step && (r_cnt == CW'(WORD_W-1) || i_last))
            r_full <= 1'b1;
         if (o_move) begin
            o_ks_data  <= w_aligned;
            o_ks_valid <= 1'b1;
         end else if (i_ks_ready) begin
            o_ks_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/trivium_seq_ctrl.sv
// Job sequencer for the Trivium core: load, warm-up, keystream run, drain.
// Optional TRIVIUM_SEQ_CTRL_ABORT_EN adds an i_abort port that cancels a running job.
module trivium_seq_ctrl
   import trivium_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int LEN_W  = 16,
   parameter int WARMUP = WARMUP_STEPS
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_start,
   input  logic [KEY_W-1:0]  i_key,
   input  logic [IV_W-1:0]   i_iv,
   input  logic [LEN_W-1:0]  i_len,
`ifdef TRIVIUM_SEQ_CTRL_ABORT_EN
   input  logic              i_abort,
`endif
   output logic              o_busy,
   output logic              o_done,
   output logic              o_core_load,
   output logic [KEY_W-1:0]  o_core_key,
   output logic [IV_W-1:0]   o_core_iv,
   output logic              o_core_step,
   input  logic              i_core_z,
   output logic [WORD_W-1:0] o_ks_data,
   output logic              o_ks_valid,
   input  logic              i_ks_ready
);
   localparam int WW = $clog2(WARMUP);
   localparam logic [2:0] ST_IDLE  = 3'(IDLE);
   localparam logic [2:0] ST_LOAD  = 3'(LOAD);
   localparam logic [2:0] ST_WARM  = 3'(WARM);
   localparam logic [2:0] ST_RUN   = 3'(RUN);
   localparam logic [2:0] ST_DRAIN = 3'(DRAIN);

   logic [2:0]       r_state;
   logic [KEY_W-1:0] r_key;
   logic [IV_W-1:0]  r_iv;
   logic [LEN_W-1:0] r_bits_left;
   logic [WW-1:0]    r_warm;
   logic             r_done;
   logic             w_abort;
   logic             w_stall;
   logic             w_move;
   logic             w_run_step;

`ifdef TRIVIUM_SEQ_CTRL_ABORT_EN
   assign w_abort = i_abort && (r_state != ST_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   assign w_run_step  = (r_state == ST_RUN) && (r_bits_left != '0) && !w_stall;
   assign o_core_step = (r_state == ST_WARM) || w_run_step;
   assign o_core_load = (r_state == ST_LOAD);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = r_done;
   assign o_core_key  = r_key;
   assign o_core_iv   = r_iv;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_key       <= '0;
         r_iv        <= '0;
         r_bits_left <= '0;
         r_warm      <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_state     <= ST_IDLE;
            r_bits_left <= '0;
            r_warm      <= '0;
         end else begin
            case (r_state)
               ST_IDLE: if (i_start) begin
                  r_key       <= i_key;
                  r_iv        <= i_iv;
                  r_bits_left <= i_len;
                  r_warm      <= '0;
                  if (i_len == '0) r_done  <= 1'b1;
                  else             r_state <= ST_LOAD;
               end
               ST_LOAD: r_state <= ST_WARM;
               ST_WARM: begin
                  if (r_warm == WW'(WARMUP-1)) r_state <= ST_RUN;
                  else                         r_warm  <= r_warm + WW'(1);
               end
               ST_RUN: begin
                  if (w_run_step) r_bits_left <= r_bits_left - LEN_W'(1);
                  // the final (possibly partial) word leaves the packer on this move
                  if (r_bits_left == '0 && w_move) r_state <= ST_DRAIN;
               end
               ST_DRAIN: if (o_ks_valid && i_ks_ready) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   ks_packer #(.WORD_W(WORD_W)) u_pack (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_clr      (w_abort),
      .i_step     (w_run_step),
      .i_z        (i_core_z),
      .i_last     (r_bits_left == LEN_W'(1)),
      .i_ks_ready (i_ks_ready),
      .o_stall    (w_stall),
      .o_move     (w_move),
      .o_ks_data  (o_ks_data),
      .o_ks_valid (o_ks_valid)
   );
endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// Randomized bench: a Trivium core model feeds the DUT, words are compared against an index-based keystream model.
module tb_trivium_seq_ctrl;
   localparam int WORD_W = 32;
   localparam int LEN_W  = 16;
   localparam int WARMUP = 1152;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ks_ready = 1'b1, abort_s = 1'b0;
   logic core_z;
   logic [79:0] key = '0, iv = '0;
   logic [LEN_W-1:0] len = '0;
   logic busy, done, core_load, core_step, ks_valid;
   logic [79:0] core_key, core_iv;
   logic [WORD_W-1:0] ks_data;

   int vectors = 0, miscompares = 0, rdy_pct = 100;
   int cyc = 0, n_load = 0, n_step = 0, n_done = 0, n_vld = 0, n_hs = 0;
   int start_cyc = 0, load_cyc = 0, first_step_cyc = 0, last_step_cyc = 0, done_cyc = 0, last_hs_cyc = 0;
   bit first_pend = 0, prev_hold = 0, prev_ok = 0;
   logic [WORD_W-1:0] prev_data = '0, last_word = '0;
   logic [WORD_W-1:0] exp_q[$];
   logic [287:0] core_s = '0;

   trivium_seq_ctrl #(.WORD_W(WORD_W), .LEN_W(LEN_W), .WARMUP(WARMUP)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_key(key), .i_iv(iv), .i_len(len),
`ifdef TRIVIUM_SEQ_CTRL_ABORT_EN
      .i_abort(abort_s),
`endif
      .o_busy(busy), .o_done(done), .o_core_load(core_load), .o_core_key(core_key),
      .o_core_iv(core_iv), .o_core_step(core_step), .i_core_z(core_z),
      .o_ks_data(ks_data), .o_ks_valid(ks_valid), .i_ks_ready(ks_ready)
   );

   always #5 clk = ~clk;

   // Trivium reference: bit i of the vector is state bit s(i+1)
   function automatic logic [287:0] triv_init(input logic [79:0] k, input logic [79:0] v);
      logic [287:0] s = '0;
      for (int i = 0; i < 80; i++) begin s[i] = k[i]; s[93+i] = v[i]; end
      s[285] = 1'b1; s[286] = 1'b1; s[287] = 1'b1;
      return s;
   endfunction

   function automatic logic triv_z(input logic [287:0] s);
      return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
   endfunction

   function automatic logic [287:0] triv_next(input logic [287:0] s);
      logic t1, t2, t3;
      logic [287:0] n;
      t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
      t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
      t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
      n = s;
      for (int i = 92; i > 0; i--) n[i] = s[i-1];
      n[0] = t3;
      for (int i = 176; i > 93; i--) n[i] = s[i-1];
      n[93] = t1;
      for (int i = 287; i > 177; i--) n[i] = s[i-1];
      n[177] = t2;
      return n;
   endfunction

   function automatic logic [3:0] raw4(input logic [79:0] k, input logic [79:0] v);
      logic [287:0] s = triv_init(k, v);
      logic [3:0] r;
      for (int i = 3; i >= 0; i--) begin r[i] = triv_z(s); s = triv_next(s); end
      return r;
   endfunction

   function automatic logic [79:0] rand80();
      logic [95:0] t = {$urandom(), $urandom(), $urandom()};
      return t[79:0];
   endfunction

   // core stand-in driven by the DUT strobes
   always @(posedge clk)
      if (core_load)      core_s <= triv_init(core_key, core_iv);
      else if (core_step) core_s <= triv_next(core_s);
   assign core_z = triv_z(core_s);

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // expected words: keystream bit i goes to word i/W, position W-1-(i%W)
   task automatic build_exp(input logic [79:0] k, input logic [79:0] v, input int n);
      logic [287:0] s = triv_init(k, v);
      logic [WORD_W-1:0] w = '0;
      for (int i = 0; i < WARMUP; i++) s = triv_next(s);
      for (int i = 0; i < n; i++) begin
         w[WORD_W-1-(i % WORD_W)] = triv_z(s);
         s = triv_next(s);
         if (i % WORD_W == WORD_W-1) begin exp_q.push_back(w); w = '0; end
      end
      if (n % WORD_W != 0) exp_q.push_back(w);
   endtask

   initial forever begin
      @(posedge clk); #1;
      ks_ready = (rdy_pct >= 100) || (int'($urandom_range(99)) < rdy_pct);
   end

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (start && !busy) start_cyc = cyc;
         if (!busy) chk("idle_quiet", {core_load, core_step}, 2'b00);
         if (core_load) begin n_load++; load_cyc = cyc; first_pend = 1; end
         if (core_step) begin
            n_step++; last_step_cyc = cyc;
            if (first_pend) begin first_step_cyc = cyc; first_pend = 0; end
         end
         if (done) begin n_done++; done_cyc = cyc; chk("done_busy", busy, 0); end
         if (ks_valid) n_vld++;
         if (prev_hold && prev_ok) begin
            chk("hold_valid", ks_valid, 1);
            chk("hold_data", ks_data, prev_data);
         end
         if (ks_valid && ks_ready) begin
            n_hs++; last_hs_cyc = cyc; last_word = ks_data;
            chk("word_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("ks_word", ks_data, exp_q.pop_front());
         end
      end
      prev_hold = rst_n && ks_valid && !ks_ready;
      prev_ok   = rst_n && !abort_s;
      prev_data = ks_data;
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_load"}, core_load, 0);
      chk({tag, "_step"}, core_step, 0);
      chk({tag, "_valid"}, ks_valid, 0);
      chk({tag, "_data"}, ks_data, 0);
      chk({tag, "_key"}, core_key, 0);
      chk({tag, "_iv"}, core_iv, 0);
   endtask

   task automatic pulse_start(input logic [79:0] k, input logic [79:0] v, input int n);
      @(posedge clk); #1;
      key = k; iv = v; len = LEN_W'(n); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key = rand80(); iv = rand80(); len = LEN_W'($urandom());
   endtask

   task automatic run_job(input string tag, input logic [79:0] k, input logic [79:0] v,
                          input int n, input int pct, input bit stray, input bit tp);
      int l0 = n_load, s0 = n_step, d0 = n_done, v0 = n_vld, h0 = n_hs, t = 0;
      int budget = (WARMUP + n) * 5 + 100;
      rdy_pct = pct;
      build_exp(k, v, n);
      pulse_start(k, v, n);
      while (n_done == d0 && t < budget) begin
         @(posedge clk); #1; t++;
         if (stray && (t == 500 || t == 1400)) begin start = 1'b1; len = LEN_W'(5); end
         else start = 1'b0;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, n_done - d0, 1);
      chk({tag, "_words_left"}, exp_q.size(), 0);
      chk({tag, "_words"}, n_hs - h0, (n + WORD_W - 1) / WORD_W);
      chk({tag, "_steps"}, n_step - s0, (n == 0) ? 0 : WARMUP + n);
      chk({tag, "_loads"}, n_load - l0, (n == 0) ? 0 : 1);
      chk({tag, "_busy_after"}, busy, 0);
      if (n == 0) begin
         chk({tag, "_done_lat"}, done_cyc, start_cyc + 1);
         chk({tag, "_valids"}, n_vld - v0, 0);
      end else begin
         chk({tag, "_load_cyc"}, load_cyc, start_cyc + 1);
         chk({tag, "_warm_start"}, first_step_cyc, load_cyc + 1);
         chk({tag, "_done_after_hs"}, done_cyc, last_hs_cyc + 1);
         if (tp) chk({tag, "_1bpc"}, last_step_cyc - first_step_cyc + 1, WARMUP + n);
      end
      if (stray) begin
         chk({tag, "_key_kept"}, core_key, k);
         chk({tag, "_iv_kept"}, core_iv, v);
      end
      exp_q.delete();
   endtask

   initial begin
      logic [79:0] k, v;
      int elens[5] = '{1, 31, 32, 33, 65};
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      chk("pin_z_zero", raw4(80'h0, 80'h0), 4'b1110);
      chk("pin_z_key1", raw4({80{1'b1}}, 80'h0) >> 3, 1'b0);
      rst_n = 1'b1;

      run_job("t1", 80'hFF000102030405060708, 80'h0, 4096, 100, 0, 1);
      run_job("t2", rand80(), rand80(), 40, 100, 0, 1);
      chk("t2_tail_zero", last_word[23:0], 24'h0);
      run_job("t3", rand80(), rand80(), 0, 100, 0, 0);
      k = rand80(); v = rand80();
      run_job("t4_stall", k, v, 1000, 30, 0, 0);
      run_job("t4_clean", k, v, 1000, 100, 0, 1);
      run_job("t5", rand80(), rand80(), 600, 100, 1, 1);
      foreach (elens[i]) run_job("edge", rand80(), rand80(), elens[i], 20 + $urandom_range(80), 0, 0);

      k = rand80(); v = rand80();
      rdy_pct = 50;
      build_exp(k, v, 1000);
      pulse_start(k, v, 1000);
      repeat (1500) @(posedge clk);
      #1;
      chk("t6_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("t6_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      run_job("t6_after", k, v, 1000, 100, 0, 1);

`ifdef TRIVIUM_SEQ_CTRL_ABORT_EN
      begin
         int d0;
         rdy_pct = 50;
         build_exp(k, v, 1000);
         pulse_start(k, v, 1000);
         repeat (1500) @(posedge clk);
         #1;
         d0 = n_done;
         abort_s = 1'b1;
         @(posedge clk); #1;
         abort_s = 1'b0;
         chk("abort_busy", busy, 0);
         chk("abort_valid", ks_valid, 0);
         repeat (10) @(posedge clk);
         #1;
         chk("abort_no_done", n_done, d0);
         exp_q.delete();
         run_job("t6_post_abort", k, v, 1000, 100, 0, 1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
